// File: rtl/tow_match_ctrl.sv
// Tug-of-war match controller: randomised wait, GO, false-start/timeout/tie
// handling and end-of-match blink on an NLED-wide rope display.
module tow_match_ctrl #(
  parameter int unsigned NLED    = 8,
  parameter int unsigned DLY_W   = 8,
  parameter int unsigned MIN_DLY = 16,
  parameter int unsigned GO_TO   = 64,
  parameter int unsigned SHOW_T  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    slowen,
  input  logic [DLY_W-1:0]        rand_in,
  input  logic                    pbl_s,
  input  logic                    pbr_s,
  input  logic                    start,
  output logic [NLED-1:0]         leds_out,
  output logic [$clog2(NLED)-1:0] pos,
  output logic                    win_l,
  output logic                    win_r,
  output logic                    fstart
);

  localparam int unsigned PW   = $clog2(NLED);
  localparam int unsigned W_GO = $clog2(GO_TO + 1);
  localparam int unsigned W_SH = $clog2(SHOW_T + 1);
  localparam int unsigned W_A  = ((DLY_W + 1) > W_GO) ? (DLY_W + 1) : W_GO;
  localparam int unsigned CW   = (W_A > W_SH) ? W_A : W_SH;

  localparam logic [PW-1:0] CENTER   = PW'(NLED / 2);
  localparam logic [PW-1:0] LEFT_END = PW'(NLED - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_SHOW,
    S_DONE
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   pos_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            blink, blink_d;
  logic            fstart_d;
  logic            pbl_q, pbr_q;
  logic            evl, evr;
  logic [CW-1:0]   wait_load;
  logic            at_end;
  logic [PW-1:0]   pos_up, pos_dn;
  logic [NLED-1:0] onehot;

  assign evl       = pbl_s & ~pbl_q;
  assign evr       = pbr_s & ~pbr_q;
  assign wait_load = CW'(MIN_DLY) + CW'(rand_in);
  assign at_end    = (pos == LEFT_END) || (pos == '0);
  assign pos_up    = (pos == LEFT_END) ? pos : pos + PW'(1);
  assign pos_dn    = (pos == '0) ? pos : pos - PW'(1);
  assign onehot    = {{(NLED-1){1'b0}}, 1'b1} << pos;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      pos    <= CENTER;
      cnt    <= '0;
      blink  <= 1'b0;
      fstart <= 1'b0;
      pbl_q  <= 1'b0;
      pbr_q  <= 1'b0;
    end else begin
      state  <= state_d;
      pos    <= pos_d;
      cnt    <= cnt_d;
      blink  <= blink_d;
      fstart <= fstart_d;
      pbl_q  <= pbl_s;
      pbr_q  <= pbr_s;
    end
  end

  always_comb begin
    state_d  = state;
    pos_d    = pos;
    cnt_d    = cnt;
    blink_d  = blink;
    fstart_d = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          cnt_d   = wait_load;
        end
      end
      S_WAIT: begin
        // A lone early press scores for the opponent; a tie counts as no press.
        if (evl ^ evr) begin
          fstart_d = 1'b1;
          pos_d    = evl ? pos_dn : pos_up;
          state_d  = S_SHOW;
          cnt_d    = CW'(SHOW_T);
        end else if (slowen) begin
          if (cnt == CW'(1)) begin
            state_d = S_GO;
            cnt_d   = CW'(GO_TO);
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
      end
      S_GO: begin
        if (evl | evr) begin
          if (evl & ~evr) pos_d = pos_up;
          if (evr & ~evl) pos_d = pos_dn;
          state_d = S_SHOW;
          cnt_d   = CW'(SHOW_T);
        end else if (slowen) begin
          if (cnt == CW'(1)) begin
            state_d = S_SHOW;
            cnt_d   = CW'(SHOW_T);
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
      end
      S_SHOW: begin
        if (slowen) begin
          if (cnt == CW'(1)) begin
            if (at_end) begin
              state_d = S_DONE;
              blink_d = 1'b1;
            end else begin
              state_d = S_WAIT;
              cnt_d   = wait_load;
            end
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_IDLE;
          pos_d   = CENTER;
          blink_d = 1'b0;
        end else if (slowen) begin
          blink_d = ~blink;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    leds_out = '0;
    unique case (state)
      S_IDLE, S_SHOW: leds_out = onehot;
      S_GO:           leds_out = '1;
      S_DONE:         leds_out = blink ? onehot : '0;
      default:        leds_out = '0;
    endcase
  end

  assign win_l = (state == S_DONE) && (pos == LEFT_END);
  assign win_r = (state == S_DONE) && (pos == '0);

endmodule
